// File: rtl/branch_predict_resolve.sv
// BTB + 2-bit BHT fetch predictor with EX-stage branch resolution and table training.
// Define BRANCH_STATS_EN to add branch / mispredict event counters.
module branch_predict_resolve #(
  parameter int XLEN      = 32,
  parameter int BTB_DEPTH = 64,
  parameter int IDX_W     = $clog2(BTB_DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] pc_if_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            valid_ex_i,
  input  logic [XLEN-1:0] pc_ex_i,
  input  logic [31:0]     inst_ex_i,
  input  logic            BrEq_i,
  input  logic            BrLt_i,
  input  logic [XLEN-1:0] alu_i,
  input  logic            pred_taken_ex_i,
  input  logic [XLEN-1:0] pred_target_ex_i,
  output logic            taken_o,
  output logic            mispredict_o,
  output logic [XLEN-1:0] redirect_pc_o
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     br_count_o,
  output logic [31:0]     mispred_count_o
`endif
);

  localparam int TAG_W = XLEN - IDX_W - 2;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [BTB_DEPTH-1:0] valid_q;
  logic [BTB_DEPTH-1:0] jal_q;
  logic [1:0]           ctr_q [BTB_DEPTH];
  logic [TAG_W-1:0]     tag_q [BTB_DEPTH];
  logic [XLEN-1:0]      tgt_q [BTB_DEPTH];

  logic [IDX_W-1:0] idx_if, idx_ex;
  logic [TAG_W-1:0] tag_if, tag_ex;
  logic             hit_if, hit_ex;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             is_branch, is_jal, is_jalr, active, br_cond;
  logic [XLEN-1:0]  act_target;

  logic unused_bits;
  assign unused_bits = ^{inst_ex_i[31:15], inst_ex_i[11:7], pc_if_i[1:0], pc_ex_i[1:0]};

  // Lookup reads the registered tables, so a same-cycle write is not bypassed.
  assign idx_if = pc_if_i[IDX_W+1:2];
  assign tag_if = pc_if_i[XLEN-1:IDX_W+2];
  assign hit_if = valid_q[idx_if] && (tag_q[idx_if] == tag_if);

  assign pred_taken_o  = ~rst_i & hit_if & (ctr_q[idx_if][1] | jal_q[idx_if]);
  assign pred_target_o = pred_taken_o ? tgt_q[idx_if] : '0;

  assign idx_ex = pc_ex_i[IDX_W+1:2];
  assign tag_ex = pc_ex_i[XLEN-1:IDX_W+2];
  assign hit_ex = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);

  assign opcode    = inst_ex_i[6:0];
  assign funct3    = inst_ex_i[14:12];
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign active    = valid_ex_i & ~rst_i;

  always_comb begin
    br_cond = 1'b0;
    case (funct3)
      3'b000:          br_cond = BrEq_i;
      3'b001:          br_cond = ~BrEq_i;
      3'b100, 3'b110:  br_cond = BrLt_i;
      3'b101, 3'b111:  br_cond = ~BrLt_i;
      default:         br_cond = 1'b0;
    endcase
  end

  assign taken_o    = active & (is_jal | is_jalr | (is_branch & br_cond));
  assign act_target = is_jalr ? {alu_i[XLEN-1:1], 1'b0} : alu_i;

  assign mispredict_o = active & ((taken_o != pred_taken_ex_i) |
                                  (taken_o & (act_target != pred_target_ex_i)));
  assign redirect_pc_o = taken_o ? act_target : pc_ex_i + XLEN'(4);

  // Tag/target arrays are not reset; valid bits alone gate their use.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) ctr_q[i] <= 2'b01;
    end else if (valid_ex_i) begin
      if (is_branch) begin
        if (hit_ex) begin
          if (taken_o) begin
            if (ctr_q[idx_ex] != 2'b11) ctr_q[idx_ex] <= ctr_q[idx_ex] + 2'b01;
            tgt_q[idx_ex] <= alu_i;
          end else if (ctr_q[idx_ex] != 2'b00) begin
            ctr_q[idx_ex] <= ctr_q[idx_ex] - 2'b01;
          end
        end else begin
          valid_q[idx_ex] <= 1'b1;
          jal_q[idx_ex]   <= 1'b0;
          tag_q[idx_ex]   <= tag_ex;
          tgt_q[idx_ex]   <= alu_i;
          ctr_q[idx_ex]   <= taken_o ? 2'b10 : 2'b01;
        end
      end else if (is_jal) begin
        valid_q[idx_ex] <= 1'b1;
        jal_q[idx_ex]   <= 1'b1;
        tag_q[idx_ex]   <= tag_ex;
        tgt_q[idx_ex]   <= alu_i;
        ctr_q[idx_ex]   <= 2'b11;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      br_count_o      <= '0;
      mispred_count_o <= '0;
    end else begin
      if (valid_ex_i & (is_branch | is_jal | is_jalr)) br_count_o <= br_count_o + 32'd1;
      if (mispredict_o) mispred_count_o <= mispred_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/branch_predict_resolve.md
Name: branch_predict_resolve

Overview:
- Parametrised successor to the EX-stage taken-control logic.
- IF side: a direct-mapped branch target buffer (BTB) plus 2-bit saturating-counter branch history table (BHT). Gives a taken/target prediction for the fetch PC.
- EX side: resolves the actual branch/jump outcome from comparator flags and the ALU target, compares it with the prediction carried down the pipe, raises mispredict/redirect, and trains the tables.

Parameters:
- XLEN, 32, datapath/PC width.
- BTB_DEPTH, 64, number of entries; power of 2, minimum 2.
- IDX_W, $clog2(BTB_DEPTH), index width. Index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2].

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- pc_if_i  in  XLEN  fetch-stage PC
- pred_taken_o  out  1  predict taken for pc_if_i
- pred_target_o  out  XLEN  predicted target (0 when pred_taken_o=0)
- valid_ex_i  in  1  EX instruction valid (not bubble/flushed)
- pc_ex_i  in  XLEN  EX instruction PC
- inst_ex_i  in  32  EX instruction word
- BrEq_i  in  1  comparator equal
- BrLt_i  in  1  comparator less-than (signedness selected upstream by funct3)
- alu_i  in  XLEN  computed target (pc+imm or rs1+imm)
- pred_taken_ex_i  in  1  prediction made for this instruction in IF, piped down
- pred_target_ex_i  in  XLEN  predicted target, piped down
- taken_o  out  1  actual outcome taken
- mispredict_o  out  1  flush IF/ID and redirect
- redirect_pc_o  out  XLEN  correct next PC when mispredict_o=1

Behaviour:
- Opcodes:
  - B-type 1100011; JAL 1101111; JALR 1100111.
  - funct3 for B-type: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
  - B-type funct3 010/011 are treated as not taken.
- taken_o (combinational) =
  - BEQ: BrEq_i; BNE: ~BrEq_i.
  - BLT/BLTU: BrLt_i; BGE/BGEU: ~BrLt_i.
  - JAL/JALR: 1.
  - Any other opcode: 0.
  - Forced 0 when valid_ex_i=0 or rst_i=1.
- Actual target = alu_i; for JALR, bit 0 is cleared.
- mispredict_o (combinational):
  - Asserted only when valid_ex_i=1 and rst_i=0.
  - Condition: (taken_o != pred_taken_ex_i) OR (taken_o AND actual target != pred_target_ex_i).
- redirect_pc_o = actual target if taken_o, else pc_ex_i+4 (mod 2^XLEN, wraps at 0xFFFFFFFC -> 0).
  - Value is don't-care when mispredict_o=0 but must be deterministic.
- Lookup (combinational, zero latency):
  - Hit = valid[idx] AND tag[idx]==tag(pc_if_i).
  - pred_taken_o = hit AND (counter[idx] MSB=1 OR jal[idx]=1).
  - pred_target_o = target[idx] if pred_taken_o, else 0.
  - During rst_i both prediction outputs are 0.
- BHT counter states: 00 SNT, 01 WNT, 10 WT, 11 ST.
  - Saturating: ST+taken stays ST; SNT+not-taken stays SNT.
- Update at posedge, only when valid_ex_i=1 and rst_i=0:
  - B-type on a hit: counter +1 if taken / -1 if not; target updated if taken.
  - B-type on a miss: allocate (valid=1, tag, jal=0, target=alu_i). Counter set to WT if taken, WNT if not.
  - JAL: allocate/overwrite (valid=1, jal=1, counter=ST, target=alu_i).
  - JALR and non-control instructions: no table write. JALR is never predicted, so it always mispredicts, redirecting to the computed target.
- Same-cycle read and write of the same index: lookup returns the pre-write contents (no bypass). The new value is visible from the next cycle.
- Reset:
  - Synchronous; clears all valid bits and sets every counter to WNT.
  - Tag/target contents are don't-care.
  - Reset mid-operation discards any pending update in that cycle.
- Aliasing: a tag mismatch is a miss. Allocation overwrites the existing entry unconditionally.

Optional Feature:
- Macro BRANCH_STATS_EN.
- When defined, add outputs br_count_o (32) and mispred_count_o (32):
  - br_count_o increments on each valid B-type/JAL/JALR in EX.
  - mispred_count_o increments on each cycle with mispredict_o=1.
  - Both clear on rst_i and wrap at 2^32.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then pc_if_i=0x100 -> pred_taken_o=0 and pred_target_o=0 for all indices; a BEQ at pc_ex_i=0x100 with BrEq_i=1, alu_i=0x140, pred_taken_ex_i=0 -> taken_o=1, mispredict_o=1, redirect_pc_o=0x140.
- Continuing from the first scenario: next cycle pc_if_i=0x100 -> pred_taken_o=1, pred_target_o=0x140 (counter WT); a not-taken BEQ resolve then moves the counter to WNT -> pred_taken_o=0.
- BNE at 0x200 resolved taken 3 times -> counter reaches ST; one not-taken resolve -> still predicts taken (WT); predicted-taken but actually not-taken -> mispredict_o=1, redirect_pc_o=0x204.
- JAL at 0x300, alu_i=0x800 -> allocated; subsequent lookup at 0x300 -> pred_taken_o=1, target 0x800; resolve with pred_taken_ex_i=1 and pred_target_ex_i=0x800 -> mispredict_o=0.
- JALR, alu_i=0x1235 -> taken_o=1, redirect_pc_o=0x1234, mispredict_o=1; lookup at its PC stays a miss. With valid_ex_i=0 -> taken_o=0, mispredict_o=0, no table change.
- Aliasing, with BTB_DEPTH=64: branch at 0x100 (index 0) trained taken, then branch at 0x200 (index 0, different tag) allocated -> lookup at 0x100 misses. Assert rst_i in the same cycle as an update -> the update is lost, all lookups miss. With BRANCH_STATS_EN, counters read 0 after the reset.
